// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake between the byte producer and the UART transmitter.
// The shared oversampling baud tick travels with the handshake so one bundle carries everything.
interface uart_tx_if;
  logic       i_tick;
  logic       i_tx_start;
  logic [7:0] i_data_byte;
  logic       o_tx_data_output;
  logic       o_busy;
  logic       o_tx_done;

  modport master (
    output i_tick, i_tx_start, i_data_byte,
    input  o_tx_data_output, o_busy, o_tx_done
  );

  modport slave (
    input  i_tick, i_tx_start, i_data_byte,
    output o_tx_data_output, o_busy, o_tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, DATA_BITS data bits LSB first, stop period of SB_TICK ticks, no parity.
// Bit timing is driven by an external oversampling tick; every output is registered.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic     i_clock,
  input  logic     i_reset,
  uart_tx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [5:0] BIT_LAST  = 6'(OVERSAMPLE - 1);
  localparam logic [5:0] STOP_LAST = 6'(SB_TICK - 1);
  localparam logic [2:0] IDX_LAST  = 3'(DATA_BITS - 1);

  state_t               state;
  logic [5:0]           tick_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 tx_line;
  logic                 busy;
  logic                 done;

  // The line register is loaded with the level of the state being entered,
  // so it moves on the same edge as the state and never passes through a stale value.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_line  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every branch reads pre-edge values.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_tx_start) begin
            shreg    <= bus.i_data_byte[DATA_BITS-1:0];
            tick_cnt <= '0;
            tx_line  <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          if (bus.i_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              tx_line  <= shreg[0];
              state    <= DATA;
            end else begin
              tick_cnt <= tick_cnt + 6'd1;
            end
          end
        end

        DATA: begin
          if (bus.i_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              shreg    <= shreg >> 1;
              if (bit_idx == IDX_LAST) begin
                tx_line <= 1'b1;
                state   <= STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
                tx_line <= shreg[1];
              end
            end else begin
              tick_cnt <= tick_cnt + 6'd1;
            end
          end
        end

        STOP: begin
          if (bus.i_tick) begin
            if (tick_cnt == STOP_LAST) begin
              tick_cnt <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 6'd1;
            end
          end
        end

        default: begin
          tx_line <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_tx_data_output = tx_line;
  assign bus.o_busy           = busy;
  assign bus.o_tx_done        = done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a tick-driven receiver model decodes every frame and
// compares it against a queue of bytes pushed when each request is driven.
module tb_uart_tx;

  localparam int OS = 16;
  localparam int NB = 8;
  localparam int SB = 16;
  localparam int FRAME_CLK = (1 + NB) * OS + SB;

  logic i_clock;
  logic i_reset;

  uart_tx_if bus ();

  uart_tx #(.DATA_BITS(NB), .OVERSAMPLE(OS), .SB_TICK(SB)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb_q[$];
  int         tick_div = 1;
  int         done_count = 0;
  int         rx_frames = 0;

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  // Tick source: one pulse every tick_div clocks, driven just after the rising edge.
  initial begin
    int phase;
    phase = 0;
    bus.i_tick = 1'b0;
    forever begin
      @(posedge i_clock);
      #1;
      if (tick_div <= 1) begin
        bus.i_tick = 1'b1;
        phase = 0;
      end else begin
        bus.i_tick = (phase == 0);
        phase = (phase + 1) % tick_div;
      end
    end
  end

  // Receiver model on the same tick: samples mid-bit, pops the scoreboard at the stop bit.
  initial begin
    bit         rx_active;
    int         rx_cnt;
    int         idx;
    logic [7:0] rx_byte;
    logic [7:0] exp_byte;
    rx_active = 1'b0;
    rx_cnt = 0;
    rx_byte = '0;
    forever begin
      @(negedge i_clock);
      if (bus.o_tx_done === 1'b1) done_count++;
      if (i_reset !== 1'b0) begin
        rx_active = 1'b0;
      end else begin
        if (!rx_active && bus.o_tx_data_output === 1'b0) begin
          rx_active = 1'b1;
          rx_cnt = 0;
        end
        if (rx_active && bus.i_tick === 1'b1) begin
          rx_cnt++;
          if (rx_cnt == OS / 2) begin
            checks++;
            if (bus.o_tx_data_output !== 1'b0) begin
              errors++;
              $display("FAIL rx_start_bit: line=%b required 0", bus.o_tx_data_output);
            end
          end else if (rx_cnt > OS / 2 && rx_cnt <= OS / 2 + NB * OS && (rx_cnt - OS / 2) % OS == 0) begin
            idx = (rx_cnt - OS / 2) / OS - 1;
            rx_byte[idx] = bus.o_tx_data_output;
          end else if (rx_cnt == (1 + NB) * OS + SB / 2) begin
            checks++;
            if (bus.o_tx_data_output !== 1'b1) begin
              errors++;
              $display("FAIL rx_stop_bit: line=%b required 1", bus.o_tx_data_output);
            end
            checks++;
            if (sb_q.size() == 0) begin
              errors++;
              $display("FAIL rx_unexpected_frame: got 0x%02h, required no frame", rx_byte);
            end else begin
              exp_byte = sb_q.pop_front();
              if (rx_byte !== exp_byte) begin
                errors++;
                $display("FAIL rx_byte: got 0x%02h required 0x%02h", rx_byte, exp_byte);
              end
            end
            rx_frames++;
            rx_active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic exp_line(input logic [7:0] b, input int n);
    if (n < OS) return 1'b0;
    if (n < (1 + NB) * OS) return b[(n - OS) / OS];
    return 1'b1;
  endfunction

  task automatic start_frame(input logic [7:0] b);
    @(posedge i_clock);
    #1;
    bus.i_tx_start  = 1'b1;
    bus.i_data_byte = b;
    sb_q.push_back(b);
    @(posedge i_clock);
    #1;
    bus.i_tx_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit ok);
    int d0;
    d0 = done_count;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge i_clock);
      #1;
      if (done_count != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lows;
    int busys;
    int d0;
    i_reset = 1'b1;
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b0;
    #1;
    checks++;
    if (bus.o_tx_data_output !== 1'b1) begin
      errors++;
      $display("FAIL reset_line: got %b required 1", bus.o_tx_data_output);
    end
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b required 0", bus.o_busy);
    end
    checks++;
    if (bus.o_tx_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b required 0", bus.o_tx_done);
    end
    lows = 0;
    busys = 0;
    d0 = done_count;
    repeat (100) begin
      @(negedge i_clock);
      if (bus.o_tx_data_output !== 1'b1) lows++;
      if (bus.o_busy !== 1'b0) busys++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL idle_line: %0d cycles not high, required 0", lows);
    end
    checks++;
    if (busys != 0 || done_count != d0) begin
      errors++;
      $display("FAIL idle_activity: busy cycles %0d done pulses %0d, required 0 and 0", busys, done_count - d0);
    end
  endtask

  task automatic test_single_frame();
    int line_err;
    int busy_err;
    int done_err;
    int d0;
    tick_div = 1;
    line_err = 0;
    busy_err = 0;
    done_err = 0;
    d0 = done_count;
    start_frame(8'hA5);
    for (int n = 0; n < FRAME_CLK + 40; n++) begin
      @(negedge i_clock);
      if (bus.o_tx_data_output !== exp_line(8'hA5, n)) line_err++;
      if (bus.o_busy !== (n < FRAME_CLK)) busy_err++;
      if (bus.o_tx_done !== (n == FRAME_CLK)) done_err++;
    end
    #1;
    checks++;
    if (line_err != 0) begin
      errors++;
      $display("FAIL frame_a5_line: %0d cycles differ from the required waveform", line_err);
    end
    checks++;
    if (busy_err != 0) begin
      errors++;
      $display("FAIL frame_a5_busy: %0d cycles differ, required busy for exactly %0d", busy_err, FRAME_CLK);
    end
    checks++;
    if (done_err != 0 || done_count - d0 != 1) begin
      errors++;
      $display("FAIL frame_a5_done: %0d misplaced cycles, %0d pulses, required 1 pulse at %0d", done_err, done_count - d0, FRAME_CLK);
    end
  endtask

  task automatic test_slow_tick();
    int   runs[$];
    int   len;
    int   d0;
    logic prev;
    tick_div = 4;
    d0 = done_count;
    len = 0;
    prev = 1'b0;
    start_frame(8'h3C);
    for (int i = 0; i < 1000; i++) begin
      @(negedge i_clock);
      #1;
      if (done_count != d0) break;
      if (bus.o_tx_data_output === prev) begin
        len++;
      end else begin
        runs.push_back(len);
        len = 1;
        prev = bus.o_tx_data_output;
      end
    end
    checks++;
    if (done_count - d0 != 1) begin
      errors++;
      $display("FAIL slow_done: got %0d pulses, required 1", done_count - d0);
    end
    checks++;
    if (runs.size() != 3) begin
      errors++;
      $display("FAIL slow_runs: got %0d level changes, required 3", runs.size());
    end else begin
      checks++;
      if (runs[1] != 4 * OS * 4 || runs[2] != 2 * OS * 4) begin
        errors++;
        $display("FAIL slow_bit_len: runs %0d/%0d, required 256/128", runs[1], runs[2]);
      end
    end
    tick_div = 1;
    repeat (8) @(posedge i_clock);
  endtask

  task automatic test_start_while_busy();
    bit ok;
    int d1;
    int r0;
    int lows;
    tick_div = 1;
    r0 = rx_frames;
    start_frame(8'h11);
    repeat (OS + 3 * OS) @(negedge i_clock);
    @(posedge i_clock);
    #1;
    bus.i_tx_start  = 1'b1;
    bus.i_data_byte = 8'hFF;
    @(posedge i_clock);
    #1;
    bus.i_tx_start  = 1'b0;
    bus.i_data_byte = 8'h00;
    wait_done(400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL busy_done_timeout: got no done pulse, required 1");
    end
    d1 = done_count;
    lows = 0;
    repeat (300) begin
      @(negedge i_clock);
      if (bus.o_tx_data_output !== 1'b1) lows++;
    end
    #1;
    checks++;
    if (lows != 0 || done_count != d1) begin
      errors++;
      $display("FAIL busy_extra_frame: %0d low cycles, %0d extra done, required 0 and 0", lows, done_count - d1);
    end
    checks++;
    if (rx_frames - r0 != 1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL busy_frames: got %0d frames (%0d pending), required 1 (0)", rx_frames - r0, sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int r0;
    tick_div = 1;
    r0 = rx_frames;
    ok = 1'b0;
    @(posedge i_clock);
    #1;
    bus.i_tx_start  = 1'b1;
    bus.i_data_byte = 8'h00;
    sb_q.push_back(8'h00);
    for (int i = 0; i < 400; i++) begin
      @(negedge i_clock);
      #1;
      if (bus.o_tx_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_first_done: got no done pulse, required 1");
    end
    bus.i_data_byte = 8'hFF;
    sb_q.push_back(8'hFF);
    @(posedge i_clock);
    #1;
    bus.i_tx_start = 1'b0;
    @(negedge i_clock);
    checks++;
    if (bus.o_tx_data_output !== 1'b0 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: line=%b busy=%b, required line=0 busy=1", bus.o_tx_data_output, bus.o_busy);
    end
    wait_done(400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_second_done: got no done pulse, required 1");
    end
    repeat (4) @(negedge i_clock);
    #1;
    checks++;
    if (rx_frames - r0 != 2 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_frames: got %0d frames (%0d pending), required 2 (0)", rx_frames - r0, sb_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int d0;
    int r0;
    tick_div = 1;
    start_frame(8'h00);
    repeat (OS + 3 * OS + OS / 2) @(negedge i_clock);
    i_reset = 1'b1;
    #1;
    checks++;
    if (bus.o_tx_data_output !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_tx_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: line=%b busy=%b done=%b, required 1 0 0",
               bus.o_tx_data_output, bus.o_busy, bus.o_tx_done);
    end
    sb_q.delete();
    d0 = done_count;
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b0;
    #1;
    checks++;
    if (done_count != d0) begin
      errors++;
      $display("FAIL midreset_done: got %0d pulses, required 0", done_count - d0);
    end
    r0 = rx_frames;
    start_frame(8'h5A);
    wait_done(400, ok);
    repeat (4) @(negedge i_clock);
    #1;
    checks++;
    if (!ok || rx_frames - r0 != 1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_recover: done=%b frames=%0d pending=%0d, required 1 1 0", ok, rx_frames - r0, sb_q.size());
    end
  endtask

  initial begin
    i_reset         = 1'b1;
    bus.i_tx_start  = 1'b0;
    bus.i_data_byte = 8'h00;
    test_reset();
    test_single_frame();
    test_slow_tick();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d bytes never received, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
